// File: rtl/dram_write_issue_queue.sv
`timescale 1ns/1ps
// Purpose : buffers latched DRAM write beats and issues them on a valid/ready port, tracking unacked writes and flush/drain.
// Latency : a beat accepted at edge N is presented as dram_req_valid from edge N; one issue per cycle when ready and under the outstanding limit.
// Backpress: be_stall from registered state only (FIFO full or not in RUN); in_valid while stalled drops the beat and sets err.
//
// Ports:
//   clk, n_rst                         clock, async active-low reset
//   in_valid/in_wdata/in_addr/in_mask  write beat from the latch
//   be_stall                           upstream must hold off in_valid
//   dram_req_*                         head-of-queue write request, valid/ready
//   dram_resp_valid                    one write acknowledged
//   flush_req / flush_done             start drain / one-cycle drain-complete pulse
//   outstanding, idle, err             unacked count, quiescent flag, sticky protocol error
module dram_write_issue_queue #(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int DRAM_ADDR_WIDTH = 32,
    parameter int MASK_WIDTH      = 5
) (
    input  logic                               clk,
    input  logic                               n_rst,
    input  logic                               in_valid,
    input  logic [63:0]                        in_wdata,
    input  logic [DRAM_ADDR_WIDTH-1:0]         in_addr,
    input  logic [MASK_WIDTH-1:0]              in_mask,
    output logic                               be_stall,
    output logic                               dram_req_valid,
    output logic [DRAM_ADDR_WIDTH-1:0]         dram_req_addr,
    output logic [63:0]                        dram_req_wdata,
    output logic [MASK_WIDTH-1:0]              dram_req_mask,
    input  logic                               dram_req_ready,
    input  logic                               dram_resp_valid,
    input  logic                               flush_req,
    output logic                               flush_done,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               idle,
    output logic                               err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DRAM_ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [63:0]                data_mem [DEPTH];
    logic [MASK_WIDTH-1:0]      mask_mem [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [OW-1:0] out_nxt;

    logic enq;
    logic deq;
    logic resp_ok;
    logic err_set;

    // Stall is derived from registered state only: a full FIFO refuses input
    // even when the head is leaving in the same cycle.
    assign be_stall       = (count == CW'(DEPTH)) || (state != ST_RUN);
    assign dram_req_valid = (count != '0) && (outstanding < OW'(MAX_OUTSTANDING));

    // Head entry drives the request; it cannot change while valid && !ready
    // because head only moves on a handshake.
    assign dram_req_addr  = addr_mem[head];
    assign dram_req_wdata = data_mem[head];
    assign dram_req_mask  = mask_mem[head];

    assign enq     = in_valid && !be_stall;
    assign deq     = dram_req_valid && dram_req_ready;
    // An ack with nothing outstanding is a protocol error and must not wrap the counter.
    assign resp_ok = dram_resp_valid && (outstanding != '0);
    assign err_set = (in_valid && be_stall) || (dram_resp_valid && (outstanding == '0));

    assign count_nxt = count + CW'(enq) - CW'(deq);
    assign out_nxt   = outstanding + OW'(deq) - OW'(resp_ok);

    assign flush_done = (state == ST_DONE);
    assign idle       = (count == '0) && (outstanding == '0) && (state == ST_RUN);

    // Drain/flush sequencing.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (flush_req) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Look at next-cycle occupancy so DONE follows the last ack edge directly.
                if ((count_nxt == '0) && (out_nxt == '0)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= '0;
            err         <= 1'b0;
        end else begin
            if (enq) begin
                tail <= tail + PW'(1);
            end
            if (deq) begin
                head <= head + PW'(1);
            end
            count       <= count_nxt;
            outstanding <= out_nxt;
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    // Storage is reset so the request fields read as zero out of reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
                mask_mem[i] <= '0;
            end
        end else if (enq) begin
            addr_mem[tail] <= in_addr;
            data_mem[tail] <= in_wdata;
            mask_mem[tail] <= in_mask;
        end
    end

endmodule

// File: tb/tb_dram_write_issue_queue.sv
`timescale 1ns/1ps
// Purpose : directed, table-driven check of dram_write_issue_queue plus hand-written multi-cycle sequences.
// Latency : inputs driven on the falling edge, outputs sampled 1ns later, state advances on the rising edge.
// Backpress: stimulus deliberately drives in_valid into be_stall once to exercise the drop/err path.
module tb_dram_write_issue_queue;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_wdata = '0;
    logic [31:0] in_addr = '0;
    logic [4:0]  in_mask = '0;
    logic        be_stall;
    logic        dram_req_valid;
    logic [31:0] dram_req_addr;
    logic [63:0] dram_req_wdata;
    logic [4:0]  dram_req_mask;
    logic        dram_req_ready = 1'b0;
    logic        dram_resp_valid = 1'b0;
    logic        flush_req = 1'b0;
    logic        flush_done;
    logic [3:0]  outstanding;
    logic        idle;
    logic        err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dram_write_issue_queue #(
        .DEPTH(4),
        .MAX_OUTSTANDING(8),
        .DRAM_ADDR_WIDTH(32),
        .MASK_WIDTH(5)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .in_valid(in_valid),
        .in_wdata(in_wdata),
        .in_addr(in_addr),
        .in_mask(in_mask),
        .be_stall(be_stall),
        .dram_req_valid(dram_req_valid),
        .dram_req_addr(dram_req_addr),
        .dram_req_wdata(dram_req_wdata),
        .dram_req_mask(dram_req_mask),
        .dram_req_ready(dram_req_ready),
        .dram_resp_valid(dram_resp_valid),
        .flush_req(flush_req),
        .flush_done(flush_done),
        .outstanding(outstanding),
        .idle(idle),
        .err(err)
    );

    typedef struct {
        logic        iv;
        logic [31:0] ia;
        logic        rdy;
        logic        rsp;
        logic        fl;
        logic        st;
        logic        rv;
        logic [31:0] ra;
        logic [3:0]  os;
        logic        idl;
        logic        er;
        logic        fd;
    } vec_t;

    vec_t vecs[$];

    // Beat payload as a function of its address; 0x100 carries the reference pattern.
    function automatic logic [63:0] dat(input logic [31:0] a);
        if (a == 32'h100) return 64'h0004_0003_0002_0001;
        return {~a, a};
    endfunction

    function automatic logic [4:0] msk(input logic [31:0] a);
        return a[7:3];
    endfunction

    function automatic void add(input logic iv, input logic [31:0] ia, input logic rdy,
                                input logic rsp, input logic fl, input logic st,
                                input logic rv, input logic [31:0] ra, input logic [3:0] os,
                                input logic idl, input logic er, input logic fd);
        vec_t v;
        v.iv = iv; v.ia = ia; v.rdy = rdy; v.rsp = rsp; v.fl = fl;
        v.st = st; v.rv = rv; v.ra = ra; v.os = os; v.idl = idl; v.er = er; v.fd = fd;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        in_valid = 1'b0; in_addr = '0; in_wdata = '0; in_mask = '0;
        dram_req_ready = 1'b0; dram_resp_valid = 1'b0; flush_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int issued;
        //      iv  addr     rdy rsp fl   st rv  req_addr os idl er fd
        // basic
        add(1, 32'h100, 1, 0, 0,  0, 0, 32'h000, 0, 1, 0, 0);
        add(0, 32'h000, 1, 0, 0,  0, 1, 32'h100, 0, 0, 0, 0);
        add(0, 32'h000, 0, 1, 0,  0, 0, 32'h000, 1, 0, 0, 0);
        add(0, 32'h000, 0, 0, 0,  0, 0, 32'h000, 0, 1, 0, 0);
        // fill with ready low, overflow beat dropped, then drain in order
        add(1, 32'h100, 0, 0, 0,  0, 0, 32'h000, 0, 1, 0, 0);
        add(1, 32'h108, 0, 0, 0,  0, 1, 32'h100, 0, 0, 0, 0);
        add(1, 32'h110, 0, 0, 0,  0, 1, 32'h100, 0, 0, 0, 0);
        add(1, 32'h118, 0, 0, 0,  0, 1, 32'h100, 0, 0, 0, 0);
        add(1, 32'h120, 0, 0, 0,  1, 1, 32'h100, 0, 0, 0, 0);
        add(0, 32'h000, 1, 0, 0,  1, 1, 32'h100, 0, 0, 1, 0);
        add(0, 32'h000, 1, 0, 0,  0, 1, 32'h108, 1, 0, 1, 0);
        add(0, 32'h000, 1, 0, 0,  0, 1, 32'h110, 2, 0, 1, 0);
        add(0, 32'h000, 1, 0, 0,  0, 1, 32'h118, 3, 0, 1, 0);
        add(0, 32'h000, 1, 1, 0,  0, 0, 32'h000, 4, 0, 1, 0);
        add(0, 32'h000, 0, 1, 0,  0, 0, 32'h000, 3, 0, 1, 0);
        add(0, 32'h000, 0, 1, 0,  0, 0, 32'h000, 2, 0, 1, 0);
        add(0, 32'h000, 0, 1, 0,  0, 0, 32'h000, 1, 0, 1, 0);
        add(0, 32'h000, 0, 0, 0,  0, 0, 32'h000, 0, 1, 1, 0);
        // enqueue+dequeue at count 2, then issue+ack at outstanding 3
        add(1, 32'h200, 0, 0, 0,  0, 0, 32'h000, 0, 1, 1, 0);
        add(1, 32'h208, 0, 0, 0,  0, 1, 32'h200, 0, 0, 1, 0);
        add(1, 32'h210, 1, 0, 0,  0, 1, 32'h200, 0, 0, 1, 0);
        add(0, 32'h000, 1, 0, 0,  0, 1, 32'h208, 1, 0, 1, 0);
        add(0, 32'h000, 1, 0, 0,  0, 1, 32'h210, 2, 0, 1, 0);
        add(1, 32'h218, 0, 0, 0,  0, 0, 32'h000, 3, 0, 1, 0);
        add(0, 32'h000, 1, 1, 0,  0, 1, 32'h218, 3, 0, 1, 0);
        add(0, 32'h000, 0, 0, 0,  0, 0, 32'h000, 3, 0, 1, 0);
        add(0, 32'h000, 0, 1, 0,  0, 0, 32'h000, 3, 0, 1, 0);
        add(0, 32'h000, 0, 1, 0,  0, 0, 32'h000, 2, 0, 1, 0);
        add(0, 32'h000, 0, 1, 0,  0, 0, 32'h000, 1, 0, 1, 0);
        // flush with 3 queued and 2 outstanding; second flush_req in DRAIN ignored
        add(1, 32'h300, 0, 0, 0,  0, 0, 32'h000, 0, 1, 1, 0);
        add(1, 32'h308, 1, 0, 0,  0, 1, 32'h300, 0, 0, 1, 0);
        add(1, 32'h310, 1, 0, 0,  0, 1, 32'h308, 1, 0, 1, 0);
        add(1, 32'h318, 0, 0, 0,  0, 1, 32'h310, 2, 0, 1, 0);
        add(1, 32'h320, 0, 0, 0,  0, 1, 32'h310, 2, 0, 1, 0);
        add(0, 32'h000, 0, 0, 1,  0, 1, 32'h310, 2, 0, 1, 0);
        add(0, 32'h000, 1, 0, 0,  1, 1, 32'h310, 2, 0, 1, 0);
        add(0, 32'h000, 1, 0, 1,  1, 1, 32'h318, 3, 0, 1, 0);
        add(0, 32'h000, 1, 0, 0,  1, 1, 32'h320, 4, 0, 1, 0);
        add(0, 32'h000, 0, 1, 0,  1, 0, 32'h000, 5, 0, 1, 0);
        add(0, 32'h000, 0, 1, 0,  1, 0, 32'h000, 4, 0, 1, 0);
        add(0, 32'h000, 0, 1, 0,  1, 0, 32'h000, 3, 0, 1, 0);
        add(0, 32'h000, 0, 1, 0,  1, 0, 32'h000, 2, 0, 1, 0);
        add(0, 32'h000, 0, 1, 0,  1, 0, 32'h000, 1, 0, 1, 0);
        add(0, 32'h000, 0, 0, 0,  1, 0, 32'h000, 0, 0, 1, 1);
        // flush when already empty: one DRAIN cycle then DONE
        add(0, 32'h000, 0, 0, 1,  0, 0, 32'h000, 0, 1, 1, 0);
        add(0, 32'h000, 0, 0, 0,  1, 0, 32'h000, 0, 0, 1, 0);
        add(0, 32'h000, 0, 0, 0,  1, 0, 32'h000, 0, 0, 1, 1);
        add(0, 32'h000, 0, 0, 0,  0, 0, 32'h000, 0, 1, 1, 0);

        // reset state
        drive_idle();
        #12;
        chk("reset be_stall", be_stall, 0);
        chk("reset req_valid", dram_req_valid, 0);
        chk("reset flush_done", flush_done, 0);
        chk("reset idle", idle, 1);
        chk("reset outstanding", outstanding, 0);
        chk("reset err", err, 0);
        chk("reset req_addr", dram_req_addr, 0);
        chk("reset req_wdata", dram_req_wdata, 0);
        chk("reset req_mask", dram_req_mask, 0);
        @(negedge clk);
        n_rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            in_valid        = vecs[i].iv;
            in_addr         = vecs[i].ia;
            in_wdata        = dat(vecs[i].ia);
            in_mask         = msk(vecs[i].ia);
            dram_req_ready  = vecs[i].rdy;
            dram_resp_valid = vecs[i].rsp;
            flush_req       = vecs[i].fl;
            #1;
            chk($sformatf("v%0d be_stall", i), be_stall, vecs[i].st);
            chk($sformatf("v%0d req_valid", i), dram_req_valid, vecs[i].rv);
            chk($sformatf("v%0d outstanding", i), outstanding, vecs[i].os);
            chk($sformatf("v%0d idle", i), idle, vecs[i].idl);
            chk($sformatf("v%0d err", i), err, vecs[i].er);
            chk($sformatf("v%0d flush_done", i), flush_done, vecs[i].fd);
            if (vecs[i].rv) begin
                chk($sformatf("v%0d req_addr", i), dram_req_addr, vecs[i].ra);
                chk($sformatf("v%0d req_wdata", i), dram_req_wdata, dat(vecs[i].ra));
                chk($sformatf("v%0d req_mask", i), dram_req_mask, msk(vecs[i].ra));
            end
        end
        @(negedge clk);
        drive_idle();

        // outstanding limit: 10 beats, ready high, no acks -> exactly 8 issue
        issued = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid       = 1'b1;
            in_addr        = 32'h400 + 32'(8 * k);
            in_wdata       = dat(in_addr);
            in_mask        = msk(in_addr);
            dram_req_ready = 1'b1;
            #1;
            if (dram_req_valid) issued++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("limit issued", 64'(issued), 8);
        chk("limit req_valid", dram_req_valid, 0);
        chk("limit outstanding", outstanding, 8);
        chk("limit be_stall", be_stall, 0);
        chk("limit head addr", dram_req_addr, 32'h440);
        dram_resp_valid = 1'b1;
        @(negedge clk);
        dram_resp_valid = 1'b0;
        #1;
        chk("limit ack req_valid", dram_req_valid, 1);
        chk("limit ack req_addr", dram_req_addr, 32'h440);
        chk("limit ack outstanding", outstanding, 7);
        @(negedge clk);
        #1;
        chk("limit reissue req_valid", dram_req_valid, 0);
        chk("limit reissue outstanding", outstanding, 8);
        chk("limit reissue head", dram_req_addr, 32'h448);

        // reset in the middle of a drain
        dram_req_ready = 1'b0;
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        #1;
        chk("drain be_stall", be_stall, 1);
        n_rst = 1'b0;
        #1;
        chk("midreset be_stall", be_stall, 0);
        chk("midreset req_valid", dram_req_valid, 0);
        chk("midreset flush_done", flush_done, 0);
        chk("midreset idle", idle, 1);
        chk("midreset outstanding", outstanding, 0);
        chk("midreset err", err, 0);
        chk("midreset req_addr", dram_req_addr, 0);
        chk("midreset req_wdata", dram_req_wdata, 0);
        chk("midreset req_mask", dram_req_mask, 0);
        @(negedge clk);
        chk("midreset hold flush_done", flush_done, 0);
        n_rst = 1'b1;
        @(negedge clk);
        #1;
        chk("postreset flush_done", flush_done, 0);
        chk("postreset err", err, 0);
        dram_resp_valid = 1'b1;
        @(negedge clk);
        dram_resp_valid = 1'b0;
        #1;
        chk("spurious ack err", err, 1);
        chk("spurious ack outstanding", outstanding, 0);
        chk("spurious ack idle", idle, 1);
        chk("spurious ack flush_done", flush_done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
